// File: rtl/sender_receiver_pkg.sv
// Shared constants and FSM state type for both ends of the serial Request/Ack link.
package sender_receiver_pkg;

    localparam int unsigned SR_WORD_W        = 16;
    localparam int unsigned SR_DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

endpackage

// File: rtl/rcv_fifo.sv
// First-word-fall-through circular FIFO holding completed receive words.
module rcv_fifo
    import sender_receiver_pkg::*;
#(
    parameter int unsigned DEPTH  = SR_DEFAULT_DEPTH,
    parameter int unsigned WORD_W = SR_WORD_W
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WORD_W-1:0]        i_wdata,
    output logic [WORD_W-1:0]        o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    // Full is judged on the pre-pop occupancy, so a push while full is dropped even with a pop.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_count   = r_count;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/receiver_control.sv
// Receiving end of the serial Request/Ack link: one bit per handshake, MSB first, into a FIFO.
// Optional RECEIVER_REQ_SYNC_EN adds two-flop synchronizers on Request and sdrDataIn.
module receiver_control
    import sender_receiver_pkg::*;
#(
    parameter int unsigned DEPTH  = SR_DEFAULT_DEPTH,
    parameter int unsigned WORD_W = SR_WORD_W
) (
    input  logic                        clk,
    input  logic                        Reset,
    input  logic                        Request,
    input  logic                        sdrDataIn,
    input  logic                        read,
    output logic                        Ack,
    output logic [WORD_W-1:0]           data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    output logic [$clog2(WORD_W)-1:0]   bitCnt
);

    localparam int unsigned BW = $clog2(WORD_W);

    logic          w_req;
    logic          w_din;
    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_ack;
    logic          w_ack_nxt;
    // Only the low WORD_W-1 bits are ever needed: the top bit would be shifted out at push.
    logic [WORD_W-2:0] r_shift;
    logic [WORD_W-2:0] w_shift_nxt;
    logic [BW-1:0] r_bitcnt;
    logic [BW-1:0] w_bitcnt_nxt;
    logic          w_push;
    logic          w_last;
    logic          w_blocked;
    logic          w_full;

`ifdef RECEIVER_REQ_SYNC_EN
    logic r_req_s1, r_req_s2, r_din_s1, r_din_s2;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_din_s1 <= 1'b0;
            r_din_s2 <= 1'b0;
        end else begin
            r_req_s1 <= Request;
            r_req_s2 <= r_req_s1;
            r_din_s1 <= sdrDataIn;
            r_din_s2 <= r_din_s1;
        end
    end

    assign w_req = r_req_s2;
    assign w_din = r_din_s2;
`else
    assign w_req = Request;
    assign w_din = sdrDataIn;
`endif

    assign w_last    = (r_bitcnt == BW'(WORD_W - 1));
    assign w_blocked = w_last && w_full;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_ack    <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ack    <= w_ack_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ack_nxt    = 1'b0;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_blocked) begin
                    w_shift_nxt = {r_shift[WORD_W-3:0], w_din};
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ACK;
                    if (w_last) begin
                        w_push       = 1'b1;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                    end
                end
            end
            ST_ACK:      w_state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!w_req) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    rcv_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (read),
        .i_wdata ({r_shift, w_din}),
        .o_rdata (data),
        .o_empty (empty),
        .o_full  (w_full),
        .o_count (count)
    );

    assign full   = w_full;
    assign Ack    = r_ack;
    assign bitCnt = r_bitcnt;

endmodule

// File: doc/receiver_control.md
Name: receiver_control

Overview:
- Receiving end of the serial Request/Ack link driven by sender_control.
- Samples one bit from sdrDataIn per Request/Ack handshake, MSB first, and assembles 16-bit words.
- Completed words go into an internal FIFO, which local logic drains with a read strobe.
- Sits opposite sender_control on the link; its Ack output drives the sender's Ack input.

Parameters:
- DEPTH, 16, FIFO depth in words; must be a power of two, at least 2.
- WORD_W, 16, word width in bits; must match sender_control.

Ports:
- clk  input  1  system clock; all flops update on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Request  input  1  from sender: the bit on sdrDataIn is valid while this is high.
- sdrDataIn  input  1  serial data from the sender's sdrDataOut.
- read  input  1  pop strobe; pops one word per cycle while high and FIFO not empty.
- Ack  output  1  to sender: one-cycle pulse acknowledging a sampled bit.
- data  output  WORD_W  FIFO head word (first-word-fall-through); valid when empty=0.
- empty  output  1  FIFO holds no words.
- full  output  1  FIFO holds DEPTH words.
- count  output  $clog2(DEPTH)+1  number of words currently stored.
- bitCnt  output  $clog2(WORD_W)  bits received so far in the current word.

Behaviour:
- Reset (asynchronous, any state, mid-word included):
  - state goes to IDLE; Ack=0, count=0, empty=1, full=0, bitCnt=0.
  - shift register and FIFO pointers are cleared; data=0.
  - A partially received word is discarded.
- State machine (Ack is registered):
  - IDLE: if Request=1 and not blocked:
    - shift <= {shift[WORD_W-2:0], sdrDataIn}; bitCnt++.
    - Ack <= 1; next state ACK.
    - If bitCnt was WORD_W-1: push {shift[WORD_W-2:0], sdrDataIn} into the FIFO and wrap bitCnt to 0.
  - Blocked means bitCnt==WORD_W-1 and full=1. While blocked, stay in IDLE with Ack=0; the sender stalls with Request held high. The bit is accepted on the first edge where full=0.
  - ACK: Ack <= 0; next state WAIT_LOW.
  - WAIT_LOW: stay until Request=0, then go to IDLE. A Request held high therefore never produces a second Ack.
- Latency:
  - Ack is high exactly one cycle, starting the edge after Request is first seen high in IDLE.
  - A pushed word is visible on data/empty/count the cycle after the push edge.
- FIFO:
  - Power-of-two circular buffer; pointers wrap naturally.
  - read while empty is ignored.
  - Push and pop on the same edge: count unchanged and both pointers advance.
  - Full is evaluated before the pop, so a push while full is blocked even if read=1 on that edge.
- Bit order: the first bit received becomes data[WORD_W-1].

Optional Feature:
- Macro: RECEIVER_REQ_SYNC_EN.
- Defined:
  - Request and sdrDataIn each pass through a two-flop synchronizer, reset to 0, before the FSM.
  - Handshake latency grows by 2 cycles; data and Request stay aligned because both take the same path.
- Undefined: both inputs feed the FSM directly, assuming the sender shares clk.

Decomposition:
- Shared package sender_receiver_pkg, used by both ends:
  - WORD_W constant.
  - State enum for IDLE, ACK, WAIT_LOW.
  - Default depth constant.
- Sub-module rcv_fifo (DEPTH, WORD_W): push, pop, FWFT data, empty, full, count.
- The FSM and shift register stay in receiver_control.

Test Plan:
- Reset mid-word: Reset after 5 bits -> Ack=0, bitCnt=0, count=0, empty=1. A following full word arrives intact.
- Single word: shift 16'h1000 MSB first with one handshake per bit -> exactly 16 Ack pulses of one cycle each. Afterwards empty=0, count=1, data=16'h1000.
- Burst: words 16'h1000..16'h100F with no reads -> full=1, count=16. Reading 16 times returns them in order, then empty=1.
- Backpressure: FIFO full and a 17th word's 16th bit with Request held high -> Ack stays 0. A single read pulse produces Ack 1 cycle later, with count=16 and full=1 again.
- Simultaneous push/pop: count=3, and the 16th bit's Ack edge coincides with read=1 -> count stays 3 and the head advances to the next word.
- Held Request: Request held high for 10 cycles -> exactly one Ack pulse and bitCnt increments by 1.
